// File: rtl/input_manager.sv
// input_manager
//   Turns the five raw board push-buttons into one-cycle key pulses for the
//   game FSM. Each button passes through a 2-flop synchronizer, a counter
//   debouncer and press-edge detection. Left/right add delayed auto-shift
//   followed by auto-repeat. Down auto-repeats from the press onwards.
//   Repeat timing counts tick_game frames.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous, active-low reset
//   tick_game  : one-cycle 60 Hz frame strobe
//   btn_*      : raw active-high buttons, asynchronous to clk
//   key_*      : registered one-cycle key pulses
module input_manager #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int DAS_FRAMES       = 10,
  parameter int ARR_FRAMES       = 2,
  parameter int SOFT_DROP_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rotate,
  input  logic btn_drop,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop
);

  // Bit order for every per-button vector: 0 left, 1 right, 2 down,
  // 3 rotate, 4 drop. Indices 0..2 also own a repeat FSM.
  localparam int NB   = 5;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0]      DAS_LIM = 9'(DAS_FRAMES);
  localparam logic [8:0]      ARR_LIM = 9'(ARR_FRAMES);
  localparam logic [8:0]      SD_LIM  = 9'(SOFT_DROP_FRAMES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DAS    = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync1_d;
  logic [NB-1:0]   sync2_q, sync2_d;
  logic [NB-1:0]   level_q, level_d;
  logic [NB-1:0]   level_prev_q, level_prev_d;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];
  logic [1:0]      state_q [3];
  logic [1:0]      state_d [3];
  logic [7:0]      frame_cnt_q [3];
  logic [7:0]      frame_cnt_d [3];
  logic [8:0]      cnt_next [3];
  logic [NB-1:0]   key_q, key_d;
  logic [NB-1:0]   rise;
  logic [2:0]      fsm_pulse;
  logic            both_lr;

  assign btn_raw = {btn_drop, btn_rotate, btn_down, btn_right, btn_left};
  assign rise    = level_q & ~level_prev_q;
  // Left and right held together cancel each other out.
  assign both_lr = level_q[0] & level_q[1];

  // The debounced level only flips after the synchronized input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreement
  // restarts the count.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Repeat FSMs. Down (index 2) skips the DAS phase. While both left and
  // right are held the counters ignore ticks; a press edge still moves the
  // FSM to DAS so it can resume cleanly once the other key is released.
  always_comb begin
    fsm_pulse = '0;
    for (int j = 0; j < 3; j++) begin
      state_d[j]     = state_q[j];
      frame_cnt_d[j] = frame_cnt_q[j];
      cnt_next[j]    = {1'b0, frame_cnt_q[j]} + 9'd1;
      if (!level_q[j]) begin
        state_d[j]     = ST_IDLE;
        frame_cnt_d[j] = '0;
      end else begin
        case (state_q[j])
          ST_IDLE: begin
            if (rise[j]) begin
              state_d[j]     = (j == 2) ? ST_REPEAT : ST_DAS;
              frame_cnt_d[j] = '0;
              fsm_pulse[j]   = 1'b1;
            end
          end
          ST_DAS: begin
            if (tick_game && !((j < 2) && both_lr)) begin
              if (cnt_next[j] == DAS_LIM) begin
                state_d[j]     = ST_REPEAT;
                frame_cnt_d[j] = '0;
                fsm_pulse[j]   = 1'b1;
              end else begin
                frame_cnt_d[j] = cnt_next[j][7:0];
              end
            end
          end
          ST_REPEAT: begin
            if (tick_game && !((j < 2) && both_lr)) begin
              if (cnt_next[j] == ((j == 2) ? SD_LIM : ARR_LIM)) begin
                frame_cnt_d[j] = '0;
                fsm_pulse[j]   = 1'b1;
              end else begin
                frame_cnt_d[j] = cnt_next[j][7:0];
              end
            end
          end
          default: begin
            state_d[j]     = ST_IDLE;
            frame_cnt_d[j] = '0;
          end
        endcase
      end
    end
  end

  // Output pulses; rotate and drop are plain press edges.
  always_comb begin
    key_d    = '0;
    key_d[0] = fsm_pulse[0] & ~both_lr;
    key_d[1] = fsm_pulse[1] & ~both_lr;
    key_d[2] = fsm_pulse[2];
    key_d[3] = rise[3];
    key_d[4] = rise[4];
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      key_q        <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int j = 0; j < 3; j++) begin
        state_q[j]     <= ST_IDLE;
        frame_cnt_q[j] <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      key_q        <= key_d;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int j = 0; j < 3; j++) begin
        state_q[j]     <= state_d[j];
        frame_cnt_q[j] <= frame_cnt_d[j];
      end
    end
  end

  assign key_left   = key_q[0];
  assign key_right  = key_q[1];
  assign key_down   = key_q[2];
  assign key_rotate = key_q[3];
  assign key_drop   = key_q[4];

endmodule

// File: tb/tb_input_manager.sv
// tb_input_manager
//   Randomized episodes of button activity drive input_manager. For each
//   episode the expected key pulses are derived from the button timing
//   (debounce latency, tick counts, left/right cancellation) and queued;
//   a monitor compares the DUT outputs against the queue every cycle.
module tb_input_manager;

  localparam int D    = 4;
  localparam int DAS  = 3;
  localparam int ARR  = 2;
  localparam int SD   = 2;
  localparam int TICK = 10;
  // Cycles from a raw change (driven in cycle c) to the debounced level.
  localparam int LAT  = D + 2;

  typedef struct {
    int         cyc;
    logic [4:0] keys;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_game = 1'b0;
  logic [4:0] btn_vec = '0;
  logic       key_left, key_right, key_down, key_rotate, key_drop;

  int   cyc = 0;
  int   tick_phase = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [4:0] exp_map [int];
  int   ep_s [5];
  int   ep_e [5];
  int   rel_s [5];
  int   rel_e [5];

  input_manager #(
    .DEBOUNCE_CYCLES (D),
    .DAS_FRAMES      (DAS),
    .ARR_FRAMES      (ARR),
    .SOFT_DROP_FRAMES(SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_game (tick_game),
    .btn_left  (btn_vec[0]),
    .btn_right (btn_vec[1]),
    .btn_down  (btn_vec[2]),
    .btn_rotate(btn_vec[3]),
    .btn_drop  (btn_vec[4]),
    .key_left  (key_left),
    .key_right (key_right),
    .key_down  (key_down),
    .key_rotate(key_rotate),
    .key_drop  (key_drop)
  );

  // Clock, cycle counter and a periodic frame tick with a random phase.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) tick_game = ((cyc % TICK) == tick_phase);

  function automatic logic [4:0] keysNow();
    return {key_drop, key_rotate, key_down, key_right, key_left};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Debounced level of key k in cycle t, from the episode's button timing.
  function automatic bit lvlHigh(input int k, input int t);
    if (ep_s[k] < 0 || (ep_e[k] - ep_s[k]) < D) return 1'b0;
    return (t >= ep_s[k] + LAT) && (t < ep_e[k] + LAT);
  endfunction

  function automatic bit blocked(input int k, input int t);
    return (k < 2) && lvlHigh(1 - k, t);
  endfunction

  task automatic addExp(input int c, input int k);
    logic [4:0] v;
    v = exp_map.exists(c) ? exp_map[c] : 5'b0;
    v[k] = 1'b1;
    exp_map[c] = v;
  endtask

  // Expected pulses: press pulse the cycle after the debounced rise, then
  // for left/right a pulse after tick DAS, DAS+ARR, ...; for down after every
  // SD-th tick. Only ticks strictly after the rise and before the fall count,
  // and none while left and right are both held.
  task automatic modelEpisode();
    for (int k = 0; k < 5; k++) begin
      int r, f, n;
      if (ep_s[k] < 0 || (ep_e[k] - ep_s[k]) < D) continue;
      r = ep_s[k] + LAT;
      f = ep_e[k] + LAT;
      if (!blocked(k, r)) addExp(r + 1, k);
      if (k < 3) begin
        n = 0;
        for (int t = r + 1; t < f; t++) begin
          if (((t % TICK) == tick_phase) && !blocked(k, t)) begin
            n++;
            if (k == 2 ? ((n % SD) == 0) : (n >= DAS && ((n - DAS) % ARR) == 0))
              addExp(t + 1, k);
          end
        end
      end
    end
  endtask

  task automatic flushExp(input int limit);
    foreach (exp_map[c]) begin
      if (c < limit) exp_q.push_back('{cyc: c, keys: exp_map[c]});
    end
    exp_map.delete();
  endtask

  task automatic clearRel();
    for (int k = 0; k < 5; k++) begin
      rel_s[k] = -1;
      rel_e[k] = -1;
    end
  endtask

  // Plays one episode described by rel_s/rel_e (offsets from its start).
  task automatic applyStimulus();
    int base, len;
    @(negedge clk);
    base = cyc;
    len  = 25;
    for (int k = 0; k < 5; k++) begin
      if (rel_s[k] >= 0) begin
        ep_s[k] = base + rel_s[k];
        ep_e[k] = base + rel_e[k];
        if (rel_e[k] + LAT + 8 > len) len = rel_e[k] + LAT + 8;
      end else begin
        ep_s[k] = -1;
        ep_e[k] = -1;
      end
    end
    modelEpisode();
    flushExp(32'h7fffffff);
    for (int off = 0; off < len; off++) begin
      for (int k = 0; k < 5; k++)
        btn_vec[k] = (rel_s[k] >= 0) && (off >= rel_s[k]) && (off < rel_e[k]);
      @(negedge clk);
    end
    btn_vec = '0;
  endtask

  // Reset while left is auto-repeating, then release reset with left held.
  task automatic resetMidRepeat();
    int base, p, r, idx;
    @(negedge clk);
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      ep_s[k] = -1;
      ep_e[k] = -1;
    end
    ep_s[0] = base;
    ep_e[0] = base + 1000;
    modelEpisode();
    p   = -1;
    idx = 0;
    foreach (exp_map[c]) begin
      if (idx == 2) p = c;
      idx++;
    end
    flushExp(p);
    btn_vec[0] = 1'b1;
    while (cyc < p) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_pre_pulse", key_left, 1);
    rst = 1'b0;
    #1;
    checkOutput("rst_drop", keysNow(), 0);
    repeat (3) @(negedge clk);
    r   = cyc;
    rst = 1'b1;
    ep_s[0] = r;
    ep_e[0] = r + 60;
    modelEpisode();
    flushExp(32'h7fffffff);
    repeat (60) @(negedge clk);
    btn_vec[0] = 1'b0;
    repeat (LAT + 8) @(negedge clk);
  endtask

  // Monitor: every cycle the outputs must equal the queued expectation for
  // that cycle, or all zero when nothing is queued for it.
  always @(negedge clk) begin : monitor
    logic [4:0] obs, want;
    obs  = keysNow();
    want = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL stale_expect: pulse %0h due at cycle %0d never compared (now %0d)",
               exp_q[0].keys, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      want = exp_q[0].keys;
      void'(exp_q.pop_front());
    end
    checkOutput("keys", obs, want);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick_phase = $urandom_range(0, TICK - 1);
    $display("[TB] tick phase %0d", tick_phase);
    repeat (4) @(negedge clk);
    checkOutput("reset_keys", keysNow(), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Short rotate glitch followed by a real rotate press.
    clearRel(); rel_s[3] = 0; rel_e[3] = $urandom_range(1, D - 1);
    applyStimulus();
    clearRel(); rel_s[3] = 0; rel_e[3] = 30;
    applyStimulus();

    // Left auto-shift and repeat.
    clearRel(); rel_s[0] = 0; rel_e[0] = 100;
    applyStimulus();

    // Soft drop.
    clearRel(); rel_s[2] = 0; rel_e[2] = 60;
    applyStimulus();

    // Left held, right pressed before left's DAS expires.
    clearRel(); rel_s[0] = 0; rel_e[0] = 120;
    rel_s[1] = $urandom_range(8, 12); rel_e[1] = rel_s[1] + 25;
    applyStimulus();

    resetMidRepeat();

    // Drop and rotate pressed in the same cycle.
    clearRel(); rel_s[3] = 0; rel_e[3] = 30; rel_s[4] = 0; rel_e[4] = 30;
    applyStimulus();

    // Random mixes of all keys, including sub-debounce glitches.
    for (int ep = 0; ep < 25; ep++) begin
      clearRel();
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          rel_s[k] = $urandom_range(0, 30);
          rel_e[k] = rel_s[k] + $urandom_range(1, 90);
        end
      end
      applyStimulus();
    end

    repeat (10) @(negedge clk);
    checkOutput("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
